adc_scan_sequencer: RTL
=======================

# adc_scan_sequencer

Multi-channel scan controller for the successive-approximation ADC. It steps an external analog multiplexer through a masked set of channels, waits a settling time, restarts and enables the SAR converter, and averages 2^AVG_LOG2 conversions per channel. Averaged results go into a per-channel result bank. It sits between the register/host logic (start, mask, readback) and one SAR converter instance.

## Interface
- NUM_CH, 4: analog channels, 2..16.
- SETTLE_CYCLES, 1000: clk cycles of mux settling after a channel switch, ≥1.
- TIMEOUT_CYCLES, 200_000: maximum clk cycles to wait for one conversion, ≥2.
- AVG_LOG2, 2: log2 of samples averaged per channel, 0..4.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle scan request.
- continuous  in  1  rescan automatically after the last channel.
- ch_mask  in  NUM_CH  enabled channels; sampled on accepted start and on each rescan.
- mux_sel  out  $clog2(NUM_CH)  analog mux channel select.
- adc_rst  out  1  one-cycle restart pulse to the SAR converter's reset.
- adc_en  out  1  SAR converter enable.
- adc_data_ready  in  1  SAR one-cycle result strobe.
- adc_data  in  16  SAR result, valid with adc_data_ready.
- busy  out  1  high whenever the state is not IDLE.
- scan_done  out  1  one-cycle pulse when a full pass finishes.
- timeout_err  out  NUM_CH  sticky per-channel timeout flags; cleared by accepted start.
- rd_ch  in  $clog2(NUM_CH)  result read index.
- rd_data  out  16  combinational read of result[rd_ch]; out-of-range index reads 0.

## Operation
- States: IDLE, SELECT, SETTLE, CONVERT, STORE, NEXT.
- IDLE: start with ch_mask≠0 latches the mask, clears timeout_err, sets ch to the lowest set bit, and goes to SELECT. start with mask=0, or start while busy, is ignored.
- SELECT, one cycle: mux_sel←ch, adc_rst=1, accumulator and sample count cleared, settle counter loaded with SETTLE_CYCLES-1, then SETTLE.
- SETTLE: count down; at 0 go to CONVERT with the timeout counter loaded.
- CONVERT: adc_en=1.
  - On adc_data_ready: acc += adc_data (acc width 16+AVG_LOG2), sample count +1, timeout counter reloaded.
  - After the 2^AVG_LOG2-th sample, go to STORE.
  - If the timeout counter reaches 0 first: set timeout_err[ch], result[ch]←16'hFFFF, go to NEXT (STORE skipped).
- STORE, one cycle: result[ch]←acc[AVG_LOG2+:16] (truncating divide).
- NEXT: go to SELECT for the next set bit above ch in the latched mask. If none remain, pulse scan_done and:
  - continuous=1: relatch ch_mask. If nonzero, go to SELECT on its lowest bit; if zero, go to IDLE.
  - continuous=0: go to IDLE.
- adc_en=0 in all states except CONVERT. A data_ready outside CONVERT is ignored.
- Results and mux_sel hold their values across passes. A channel not scanned keeps its old result.
- ch_mask changes during a pass have no effect until the next relatch.
- Reset values: state=IDLE, mux_sel=0, adc_rst=0, adc_en=0, busy=0, scan_done=0, timeout_err=0, all result[]=0. Reset mid-scan aborts immediately; no scan_done is produced.

## Timing
- Accepted start at edge N: SELECT during N+1, adc_rst high in N+1, SETTLE from N+2, adc_en high from N+2+SETTLE_CYCLES.
- Per channel: 1 + SETTLE_CYCLES + conversion time + 1 (STORE) + 1 (NEXT) cycles.
- The result is visible on rd_data the cycle after STORE.
- The scan_done pulse coincides with the NEXT cycle of the last channel.
- With continuous=1, SELECT follows directly on the next cycle.
- data_ready in the same cycle the timeout counter hits 0: the sample wins, and no timeout is flagged.

## Structure
- Package adc_pkg: state enum scan_state_t, and the constant TIMEOUT_RESULT = 16'hFFFF.
- One sub-module, priority_next_ch: combinational "next set bit above index" finder, used for both first-channel and next-channel selection.
- Counters are inline. The existing downcounter is not reused because it needs a reloadable period.

## Test plan
- NUM_CH=4, mask=4'b0101, AVG_LOG2=2, SAR model returning 16'h0100, 0x0200, 0x0300, 0x0400 → result[0]=16'h0280, result[2]=16'h0280, mux_sel visits 0 then 2, one scan_done, result[1] stays 0.
- mask=0 with start → busy stays 0, no scan_done, no adc_rst.
- SAR model never asserts data_ready on ch1, mask=4'b0011 → timeout_err=4'b0010, result[1]=16'hFFFF, ch0 valid, scan_done after TIMEOUT_CYCLES.
- continuous=1, mask changed from 4'b0001 to 4'b1000 mid-pass → the next pass scans only ch3. Dropping continuous → IDLE after that pass.
- reset asserted during SETTLE and during CONVERT → the next cycle shows every output at its reset value; a following start runs a clean scan.
- start pulsed while busy, and a data_ready injected during SETTLE → both ignored; results equal an undisturbed run.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC scan sequencer.
package adc_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] TIMEOUT_RESULT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    SETTLE  = 3'd2,
    CONVERT = 3'd3,
    STORE   = 3'd4,
    NEXT    = 3'd5
  } scan_state_t;

endpackage

// File: rtl/priority_next_ch.sv
// Finds the lowest set bit of mask at or above index 'from'.
module priority_next_ch #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         mask,
  input  logic [$clog2(NUM_CH):0]   from,
  output logic                      found,
  output logic [$clog2(NUM_CH)-1:0] ch
);

  localparam int IDX_W = $clog2(NUM_CH);

  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    found = 1'b0;
    ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        found = 1'b1;
        ch    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Steps the analog mux through the masked channels, drives the SAR converter and
// stores the per-channel average of 2^AVG_LOG2 conversions in a result bank.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int AVG_LOG2       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [NUM_CH-1:0]         ch_mask,
  output logic [$clog2(NUM_CH)-1:0] mux_sel,
  output logic                      adc_rst,
  output logic                      adc_en,
  input  logic                      adc_data_ready,
  input  logic [DATA_W-1:0]         adc_data,
  output logic                      busy,
  output logic                      scan_done,
  output logic [NUM_CH-1:0]         timeout_err,
  input  logic [$clog2(NUM_CH)-1:0] rd_ch,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LOAD     = TO_W'(TIMEOUT_CYCLES - 1);

  scan_state_t state, state_nxt;

  logic [NUM_CH-1:0] mask_q;
  logic [IDX_W-1:0]  ch;
  logic [IDX_W:0]    ch_plus1;
  logic [ACC_W-1:0]  acc;
  logic [SCNT_W-1:0] sample_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [TO_W-1:0]   tmo_cnt;
  logic [DATA_W-1:0] result [NUM_CH];

  logic             first_found, next_found;
  logic [IDX_W-1:0] first_ch, next_ch;
  logic             accept, sample_last, tmo_hit;

  assign ch_plus1    = (IDX_W + 1)'(ch) + (IDX_W + 1)'(1);
  assign accept      = (state == IDLE) && start && (ch_mask != '0);
  assign sample_last = adc_data_ready && (sample_cnt == LAST_SAMPLE);
  // A strobe arriving on the final timeout cycle still counts as a sample.
  assign tmo_hit     = (state == CONVERT) && !adc_data_ready && (tmo_cnt == '0);

  priority_next_ch #(.NUM_CH(NUM_CH)) u_first (
    .mask  (ch_mask),
    .from  ({(IDX_W + 1){1'b0}}),
    .found (first_found),
    .ch    (first_ch)
  );

  priority_next_ch #(.NUM_CH(NUM_CH)) u_next (
    .mask  (mask_q),
    .from  (ch_plus1),
    .found (next_found),
    .ch    (next_ch)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SELECT;
      SELECT:  state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = CONVERT;
      CONVERT: begin
        if (sample_last)  state_nxt = STORE;
        else if (tmo_hit) state_nxt = NEXT;
      end
      STORE:   state_nxt = NEXT;
      NEXT: begin
        if (next_found)                     state_nxt = SELECT;
        else if (continuous && first_found) state_nxt = SELECT;
        else                                state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    adc_rst   = (state == SELECT);
    adc_en    = (state == CONVERT);
    scan_done = (state == NEXT) && !next_found;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q      <= '0;
      ch          <= '0;
      mux_sel     <= '0;
      timeout_err <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mask_q      <= ch_mask;
            ch          <= first_ch;
            timeout_err <= '0;
          end
        end
        SELECT:  mux_sel <= ch;
        CONVERT: if (tmo_hit) timeout_err[ch] <= 1'b1;
        NEXT: begin
          if (next_found) begin
            ch <= next_ch;
          end else if (continuous) begin
            mask_q <= ch_mask;
            ch     <= first_ch;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
    end else if (state == STORE) begin
      result[ch] <= acc[AVG_LOG2 +: DATA_W];
    end else if (tmo_hit) begin
      result[ch] <= TIMEOUT_RESULT;
    end
  end

  // Datapath counters are always initialised in SELECT/SETTLE before use.
  always_ff @(posedge clk) begin
    case (state)
      SELECT: begin
        acc        <= '0;
        sample_cnt <= '0;
        settle_cnt <= SETTLE_LOAD;
      end
      SETTLE: begin
        if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
        else                  tmo_cnt    <= TO_LOAD;
      end
      CONVERT: begin
        if (adc_data_ready) begin
          acc        <= acc + ACC_W'(adc_data);
          sample_cnt <= sample_cnt + SCNT_W'(1);
          tmo_cnt    <= TO_LOAD;
        end else begin
          tmo_cnt    <= tmo_cnt - TO_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_ch) < NUM_CH) rd_data = result[rd_ch];
  end

endmodule
